// File: rtl/dp_fifo_pkg.sv
// dp_fifo_pkg
//   Shared definitions for the dp_fifo datapath FIFO and its storage sub-module.
//   Provides:
//     DEFAULT_DATAWIDTH / DEFAULT_DEPTH  default sizing of the FIFO
//     clog2()                            pointer width helper usable in parameter lists
//     is_legal_depth()                   DEPTH legality rule (power of 2, at least 2)
//     fifo_op_e                          per-cycle operation, {write accepted, read accepted}
package dp_fifo_pkg;

  localparam int DEFAULT_DATAWIDTH = 64;
  localparam int DEFAULT_DEPTH     = 8;

  // Ceiling log2. Kept local so it can be evaluated in parameter port lists.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Pointers wrap by natural overflow, so DEPTH must be a power of two.
  function automatic bit is_legal_depth(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Encoding matches {wr_accept, rd_accept} so it can be cast directly.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/dp_fifo_ram.sv
// fifo_ram
//   DEPTH x DATAWIDTH simple dual-port storage for dp_fifo.
//   Ports:
//     Clk      in   clock, posedge
//     Rst      in   synchronous active-high reset; clears only the read register
//     wr_en    in   write strobe (already qualified by the caller)
//     wr_addr  in   write address
//     wr_data  in   write word
//     rd_en    in   read strobe (already qualified by the caller)
//     rd_addr  in   read address
//     rd_data  out  registered read word; holds its value when rd_en is low
module fifo_ram
  import dp_fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  localparam int ADDRW    = clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 wr_en,
  input  logic [ADDRW-1:0]     wr_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDRW-1:0]     rd_addr,
  output logic [DATAWIDTH-1:0] rd_data
);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  // The array itself is deliberately not reset so it can map onto RAM macros.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read and write never target the same entry in one cycle: the controller
  // only allows that when the FIFO is empty or full, where one side is blocked.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dp_fifo.sv
// dp_fifo
//   Single-clock FIFO with registered read, occupancy count and sticky
//   overflow/underflow flags. Storage lives in fifo_ram; this level keeps the
//   pointers, the occupancy counter and the flags.
//   Ports:
//     Clk        in   clock, posedge
//     Rst        in   synchronous active-high reset
//     wr_en      in   write request
//     wr_data    in   word to write
//     full       out  no free entry; writes are dropped
//     rd_en      in   read request
//     rd_data    out  registered read word
//     rd_valid   out  rd_data was updated on the last edge
//     empty      out  no stored entry; reads are ignored
//     count      out  occupancy, 0..DEPTH
//     overflow   out  sticky, a write arrived while full
//     underflow  out  sticky, a read arrived while empty
module dp_fifo
  import dp_fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  localparam int ADDRW    = clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 full,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic [ADDRW:0]       count,
  output logic                 overflow,
  output logic                 underflow
);

  generate
    if (!is_legal_depth(DEPTH)) begin : g_bad_depth
      $error("dp_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  localparam logic [ADDRW:0]   FULL_COUNT = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0]   COUNT_ONE  = (ADDRW + 1)'(1);
  localparam logic [ADDRW-1:0] PTR_ONE    = ADDRW'(1);

  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic             wr_accept;
  logic             rd_accept;
  fifo_op_e         op;

  // Flags come from the registered count, so they change only after the edge
  // that changes occupancy.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;
  assign op        = fifo_op_e'({wr_accept, rd_accept});

  fifo_ram #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .Clk     (Clk),
    .Rst     (Rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else begin
      case (op)
        OP_WRITE: count <= count + COUNT_ONE;
        OP_READ:  count <= count - COUNT_ONE;
        default:  count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dp_fifo.sv
// tb_dp_fifo
//   Self-checking bench for dp_fifo (DATAWIDTH=64, DEPTH=8): a fixed vector
//   table, hand-written corner sequences and a randomized run, all checked
//   against a queue-based reference model.
module tb_dp_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          Clk;
  logic          Rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_rdata;
  bit            model_valid;
  bit            model_ovf;
  bit            model_udf;

  typedef struct {
    bit            rst;
    bit            wr;
    bit            rd;
    logic [DW-1:0] data;
    int            exp_count;
    bit            exp_valid;
    logic [DW-1:0] exp_rdata;
    bit            exp_ovf;
    bit            exp_udf;
  } vec_t;

  vec_t vecs[$];

  dp_fifo #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // FIFO behaviour as a plain queue: pop on an allowed read, push on an allowed write.
  task automatic modelStep(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    bit was_full;
    bit was_empty;
    if (r) begin
      model_q.delete();
      model_rdata = '0;
      model_valid = 0;
      model_ovf   = 0;
      model_udf   = 0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (rd && !was_empty) begin
        model_rdata = model_q.pop_front();
        model_valid = 1;
      end else begin
        model_valid = 0;
      end
      if (w && !was_full) model_q.push_back(d);
      if (w && was_full)  model_ovf = 1;
      if (rd && was_empty) model_udf = 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"},     DW'(count),     DW'(model_q.size()));
    check({tag, ".empty"},     DW'(empty),     DW'(model_q.size() == 0));
    check({tag, ".full"},      DW'(full),      DW'(model_q.size() == DEPTH));
    check({tag, ".rd_valid"},  DW'(rd_valid),  DW'(model_valid));
    check({tag, ".rd_data"},   rd_data,        model_rdata);
    check({tag, ".overflow"},  DW'(overflow),  DW'(model_ovf));
    check({tag, ".underflow"}, DW'(underflow), DW'(model_udf));
  endtask

  // Drive one cycle away from the edge, advance the model at the edge, check after it.
  task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [DW-1:0] d,
                               input string tag);
    @(negedge Clk);
    Rst     = r;
    wr_en   = w;
    rd_en   = rd;
    wr_data = d;
    @(posedge Clk);
    modelStep(r, w, rd, d);
    #1;
    checkOutput(tag);
  endtask

  function automatic vec_t mk(input bit r, input bit w, input bit rd, input logic [DW-1:0] d,
                              input int c, input bit v, input logic [DW-1:0] q,
                              input bit o, input bit u);
    vec_t t;
    t.rst = r; t.wr = w; t.rd = rd; t.data = d;
    t.exp_count = c; t.exp_valid = v; t.exp_rdata = q; t.exp_ovf = o; t.exp_udf = u;
    return t;
  endfunction

  initial begin
    Rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_rdata = '0;
    model_valid = 0;
    model_ovf   = 0;
    model_udf   = 0;

    // Reset, in-order readback, underflow, and write+read at empty.
    vecs.push_back(mk(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h11, 1, 0, 64'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h22, 2, 0, 64'h0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 64'h33, 3, 0, 64'h0,  0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0,  2, 1, 64'h11, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0,  1, 1, 64'h22, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0,  0, 1, 64'h33, 0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0,  0, 0, 64'h33, 0, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0));
    vecs.push_back(mk(0, 1, 1, 64'hAA, 1, 0, 64'h0,  0, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,  0, 1, 64'hAA, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_count", i), DW'(count), DW'(vecs[i].exp_count));
      check($sformatf("vec%0d.tbl_empty", i), DW'(empty), DW'(vecs[i].exp_count == 0));
      check($sformatf("vec%0d.tbl_valid", i), DW'(rd_valid), DW'(vecs[i].exp_valid));
      check($sformatf("vec%0d.tbl_rdata", i), rd_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d.tbl_ovf", i),   DW'(overflow), DW'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.tbl_udf", i),   DW'(underflow), DW'(vecs[i].exp_udf));
    end

    // Fill past full: the ninth word is dropped and only words 1..8 come back.
    applyStimulus(1, 0, 0, '0, "full.rst");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 1, 0, DW'(i), $sformatf("full.wr%0d", i));
      if (i == 8) check("full.after8", DW'(full), DW'(1));
    end
    check("full.ovf", DW'(overflow), DW'(1));
    check("full.count", DW'(count), DW'(8));
    applyStimulus(0, 1, 1, 64'hDEAD, "full.wr_rd");
    check("full.wr_rd_count", DW'(count), DW'(7));
    check("full.wr_rd_data", rd_data, DW'(1));
    for (int i = 2; i <= 8; i++) begin
      applyStimulus(0, 0, 1, '0, $sformatf("full.rd%0d", i));
      check($sformatf("full.rd%0d_data", i), rd_data, DW'(i));
    end
    check("full.empty_end", DW'(empty), DW'(1));

    // Fill 6, drain 4, then stream through the pointer wrap with count held at 2.
    applyStimulus(1, 0, 0, '0, "wrap.rst");
    for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 0, DW'(i), "wrap.fill");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, '0, "wrap.drain");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, DW'(7 + i), $sformatf("wrap.both%0d", i));
      check($sformatf("wrap.count%0d", i), DW'(count), DW'(2));
      check($sformatf("wrap.data%0d", i), rd_data, DW'(5 + i));
    end

    // Reset in the middle of traffic discards the stored words.
    applyStimulus(1, 0, 0, '0, "mid.rst0");
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, DW'(64'h50 + i), "mid.fill");
    check("mid.count5", DW'(count), DW'(5));
    applyStimulus(1, 1, 1, 64'h99, "mid.rst");
    check("mid.count0", DW'(count), DW'(0));
    applyStimulus(0, 0, 1, '0, "mid.rd");
    check("mid.rd_valid", DW'(rd_valid), DW'(0));
    check("mid.udf", DW'(underflow), DW'(1));

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 400; i++) begin
      int phase;
      bit r, w, rd;
      phase = (i / 40) % 3;
      r  = ($urandom_range(0, 59) == 0);
      w  = (phase == 0) ? ($urandom_range(0, 9) < 8) :
           (phase == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1) == 1;
      rd = (phase == 0) ? ($urandom_range(0, 9) < 2) :
           (phase == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1) == 1;
      applyStimulus(r, w, rd, {$urandom, $urandom}, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
